// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and width helpers for fifo_wr_arbiter.
// FIFO_ARB_TAG_EN widens the FIFO write data by the requester id.
package fifo_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
`ifdef FIFO_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  function automatic int idw_of(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int data_w(int width, int n);
    return width + (TAG_EN ? idw_of(n) : 0);
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid request at or after ptr+1 (mod N).
module rr_pick import fifo_arb_pkg::*; #(
  parameter int N = 4,
  localparam int IDW = idw_of(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] idx,
  output logic           any
);
  logic [IDW-1:0] j;
  // scan farthest-first so the nearest valid request overwrites the result
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IDW'((int'(ptr) + k) % N);
      if (req[j]) idx = j;
    end
  end
  assign any = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the async FIFO write port among N requesters.
// Define FIFO_ARB_TAG_EN to prepend grant_id to fifo_wr_data.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int MAX_BURST = 4,
  parameter int IDLE_TMO = 8,
  localparam int IDW = idw_of(N),
  localparam int DW = data_w(WIDTH, N)
) (
  input  logic             wr_clk,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  input  logic             fifo_wr_full,
  output logic             fifo_wr_en,
  output logic [DW-1:0]    fifo_wr_data,
  output logic [IDW-1:0]   grant_id,
  output logic             busy
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TMO + 1);
  state_t state, state_n;
  logic [IDW-1:0] ptr, pick;
  logic any, g_valid, accept, rel;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [WIDTH-1:0] g_data;

  rr_pick #(.N(N)) u_pick (.req(req_valid), .ptr(ptr), .idx(pick), .any(any));

  assign g_valid = req_valid[grant_id];
  assign accept = state == GRANT && g_valid && !fifo_wr_full;
  assign g_data = req_data[grant_id*WIDTH +: WIDTH];
  assign busy = state == GRANT;
  assign fifo_wr_en = accept;
  assign req_ready = accept ? N'(1) << grant_id : '0;
`ifdef FIFO_ARB_TAG_EN
  assign fifo_wr_data = {grant_id, g_data};
`else
  assign fifo_wr_data = g_data;
`endif
  // a full FIFO freezes the whole grant, timeout included
  assign rel = state == GRANT && !fifo_wr_full &&
    (accept ? (req_last[grant_id] || beat_cnt == BW'(MAX_BURST - 1)) : tmo_cnt == TW'(IDLE_TMO - 1));

  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (any ? GRANT : IDLE) : (rel ? IDLE : GRANT);
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant_id <= '0;
      ptr <= IDW'(N - 1);
      beat_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any) grant_id <= pick;
      if (rel) begin
        ptr <= grant_id;
        beat_cnt <= '0;
        tmo_cnt <= '0;
      end else if (state == GRANT && !fifo_wr_full) begin
        if (g_valid) begin
          tmo_cnt <= '0;
          beat_cnt <= beat_cnt == BW'(MAX_BURST - 1) ? beat_cnt : beat_cnt + BW'(1);
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end
endmodule
